// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared datapath widths and ALU opcode constants for the CPU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int CPU_DATA_W = 16;
   localparam int CPU_ADDR_W = 3;

   localparam logic [3:0] ALU_PASS = 4'b0000;
   localparam logic [3:0] ALU_INC  = 4'b0010;
   localparam logic [3:0] ALU_DEC  = 4'b0011;
   localparam logic [3:0] ALU_ADD  = 4'b0100;
   localparam logic [3:0] ALU_SUB  = 4'b0101;
   localparam logic [3:0] ALU_SHR  = 4'b0110;
   localparam logic [3:0] ALU_SHL  = 4'b0111;

endpackage

`default_nettype wire

// File: rtl/cpu_exec_unit_if.sv
// ============================================================================
// Module   : cpu_exec_unit_if
// Brief    : Control-word and result bus between the control unit and the
//            execution unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cpu_exec_unit_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic [ADDR_W-1:0] W_Adr;
   logic [ADDR_W-1:0] R_Adr;
   logic [ADDR_W-1:0] S_Adr;
   logic              s_sel;
   logic              rw_en;
   logic [3:0]        alu_op;
   logic [DATA_W-1:0] DS;
   logic [DATA_W-1:0] Reg_Out;
   logic [DATA_W-1:0] Alu_Out;
   logic [DATA_W-1:0] S_Out;
   logic              N;
   logic              Z;
   logic              C;

   modport master (
      output W_Adr, R_Adr, S_Adr, s_sel, rw_en, alu_op, DS,
      input  Reg_Out, Alu_Out, S_Out, N, Z, C
   );

   modport slave (
      input  W_Adr, R_Adr, S_Adr, s_sel, rw_en, alu_op, DS,
      output Reg_Out, Alu_Out, S_Out, N, Z, C
   );
endinterface

`default_nettype wire

// File: rtl/cpu_regfile.sv
// ============================================================================
// Module   : cpu_regfile
// Brief    : 2**ADDR_W x DATA_W register file, one write port, two
//            combinational read ports, asynchronous active-low clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_regfile #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              we,
   input  wire logic [ADDR_W-1:0] waddr,
   input  wire logic [DATA_W-1:0] wdata,
   input  wire logic [ADDR_W-1:0] raddr_r,
   input  wire logic [ADDR_W-1:0] raddr_s,
   output logic      [DATA_W-1:0] rdata_r,
   output logic      [DATA_W-1:0] rdata_s
);
   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (we) regs_d[waddr] = wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // No write bypass: reads see the pre-edge contents.
   assign rdata_r = regs_q[raddr_r];
   assign rdata_s = regs_q[raddr_s];
endmodule

`default_nettype wire

// File: rtl/cpu_exec_unit.sv
// ============================================================================
// Module   : cpu_exec_unit
// Brief    : Register file plus 16-bit ALU; produces N/Z/C for the control unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_exec_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int ADDR_W = CPU_ADDR_W
) (
   input wire logic         clk,
   input wire logic         reset,
   cpu_exec_unit_if.slave   bus
);
   logic [DATA_W-1:0] r_op;
   logic [DATA_W-1:0] s_reg;
   logic [DATA_W-1:0] s_op;
   logic [DATA_W:0]   alu_res;

   cpu_regfile #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .we      (bus.rw_en),
      .waddr   (bus.W_Adr),
      .wdata   (alu_res[DATA_W-1:0]),
      .raddr_r (bus.R_Adr),
      .raddr_s (bus.S_Adr),
      .rdata_r (r_op),
      .rdata_s (s_reg)
   );

   assign s_op = bus.s_sel ? bus.DS : s_reg;

   // Bit DATA_W of the extended result is the carry, borrow or shifted-out bit.
   always_comb begin
      alu_res = {1'b0, s_op};
      case (bus.alu_op)
         ALU_INC: alu_res = {1'b0, s_op} + {{DATA_W{1'b0}}, 1'b1};
         ALU_DEC: alu_res = {1'b0, s_op} - {{DATA_W{1'b0}}, 1'b1};
         ALU_ADD: alu_res = {1'b0, r_op} + {1'b0, s_op};
         ALU_SUB: alu_res = {1'b0, r_op} - {1'b0, s_op};
         ALU_SHR: alu_res = {s_op[0], 1'b0, s_op[DATA_W-1:1]};
         ALU_SHL: alu_res = {s_op, 1'b0};
         default: alu_res = {1'b0, s_op};
      endcase
   end

   assign bus.Reg_Out = r_op;
   assign bus.S_Out   = s_reg;
   assign bus.Alu_Out = alu_res[DATA_W-1:0];
   assign bus.N       = alu_res[DATA_W-1];
   assign bus.Z       = (alu_res[DATA_W-1:0] == '0);
   assign bus.C       = alu_res[DATA_W];
endmodule

`default_nettype wire

// File: tb/tb_cpu_exec_unit.sv
// ============================================================================
// Module   : tb_cpu_exec_unit
// Brief    : Directed self-checking bench for cpu_exec_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_exec_unit;
   import cpu_pkg::*;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   cpu_exec_unit_if #(.DATA_W(16), .ADDR_W(3)) bus ();

   cpu_exec_unit #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] w, input logic [2:0] r, input logic [2:0] s,
                        input logic ssel, input logic we, input logic [3:0] op,
                        input logic [15:0] ds);
      bus.W_Adr  = w;
      bus.R_Adr  = r;
      bus.S_Adr  = s;
      bus.s_sel  = ssel;
      bus.rw_en  = we;
      bus.alu_op = op;
      bus.DS     = ds;
   endtask

   // Load a register through the DS pass path; returns 1 ns after the edge.
   task automatic load(input logic [2:0] a, input logic [15:0] v);
      drive(a, 3'd0, 3'd0, 1'b1, 1'b1, ALU_PASS, v);
      @(posedge clk);
      #1;
      bus.rw_en = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
      drive(3'd0, a, a, 1'b0, 1'b0, ALU_PASS, 16'h0);
      #1;
      chk(tag, {16'h0, bus.Reg_Out}, {16'h0, exp});
   endtask

   // Apply a DS-sourced op and check result and {N,Z,C}.
   task automatic ds_op(input string tag, input logic [3:0] op, input logic [15:0] ds,
                        input logic [15:0] exp_res, input logic [2:0] exp_nzc);
      drive(3'd0, 3'd0, 3'd0, 1'b1, 1'b0, op, ds);
      #1;
      chk(tag, {13'h0, bus.N, bus.Z, bus.C, bus.Alu_Out}, {13'h0, exp_nzc, exp_res});
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      drive(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ALU_PASS, 16'h0);
      #2;
      chk("reset_state", {bus.Reg_Out, bus.S_Out}, 32'h0);
      chk("reset_flags", {13'h0, bus.N, bus.Z, bus.C, bus.Alu_Out}, {13'h0, 3'b010, 16'h0});
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Asynchronous clear mid-cycle
      for (int i = 0; i < 8; i++) load(3'(i), 16'hA5A5);
      rd("preload_r7", 3'd7, 16'hA5A5);
      #2;
      reset = 1'b0;
      #1;
      for (int i = 0; i < 8; i += 3) begin
         bus.R_Adr = 3'(i);
         bus.S_Adr = 3'(7 - i);
         #1;
         chk("async_clear", {bus.Reg_Out, bus.S_Out}, 32'h0);
      end
      chk("async_flags", {29'h0, bus.N, bus.Z, bus.C}, {29'h0, 3'b010});
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // LDI path
      drive(3'd2, 3'd0, 3'd0, 1'b1, 1'b1, ALU_PASS, 16'h8001);
      #1;
      chk("ldi_pre", {13'h0, bus.N, bus.Z, bus.C, bus.Alu_Out}, {13'h0, 3'b100, 16'h8001});
      @(posedge clk);
      #1;
      rd("ldi_r2", 3'd2, 16'h8001);

      // ADD with carry out
      load(3'd1, 16'hFFFF);
      load(3'd2, 16'h0001);
      load(3'd3, 16'h1234);
      drive(3'd3, 3'd1, 3'd2, 1'b0, 1'b1, ALU_ADD, 16'h5555);
      #1;
      chk("add_carry", {13'h0, bus.N, bus.Z, bus.C, bus.Alu_Out}, {13'h0, 3'b011, 16'h0000});
      @(posedge clk);
      #1;
      rd("add_wr_r3", 3'd3, 16'h0000);

      // SUB borrow, no write
      load(3'd1, 16'd5);
      load(3'd2, 16'd7);
      drive(3'd1, 3'd1, 3'd2, 1'b0, 1'b0, ALU_SUB, 16'h0);
      #1;
      chk("sub_borrow", {13'h0, bus.N, bus.Z, bus.C, bus.Alu_Out}, {13'h0, 3'b101, 16'hFFFE});
      @(posedge clk);
      #1;
      rd("sub_nowr_r1", 3'd1, 16'd5);
      rd("sub_nowr_r2", 3'd2, 16'd7);

      // Shifts and inc/dec edges
      ds_op("shl",     ALU_SHL, 16'h8001, 16'h0002, 3'b001);
      ds_op("shr",     ALU_SHR, 16'h8001, 16'h4000, 3'b001);
      ds_op("shr_c0",  ALU_SHR, 16'h0002, 16'h0001, 3'b000);
      ds_op("dec_one", ALU_DEC, 16'h0001, 16'h0000, 3'b010);
      ds_op("dec_zero",ALU_DEC, 16'h0000, 16'hFFFF, 3'b101);
      ds_op("inc_wrap",ALU_INC, 16'hFFFF, 16'h0000, 3'b011);
      ds_op("inc",     ALU_INC, 16'h7FFF, 16'h8000, 3'b100);
      ds_op("rsv_0001",4'b0001, 16'h8000, 16'h8000, 3'b100);

      // Read-during-write: INC R4,R4 increments once per edge
      load(3'd4, 16'd9);
      drive(3'd4, 3'd4, 3'd4, 1'b0, 1'b1, ALU_INC, 16'h0);
      #1;
      chk("rdw_old", {bus.Reg_Out, bus.S_Out}, {16'd9, 16'd9});
      chk("rdw_alu", {16'h0, bus.Alu_Out}, {16'h0, 16'd10});
      @(posedge clk);
      #1;
      chk("rdw_new", {bus.Reg_Out, bus.S_Out}, {16'd10, 16'd10});
      @(posedge clk);
      #1;
      bus.rw_en = 1'b0;
      chk("rdw_twice", {16'h0, bus.Reg_Out}, {16'h0, 16'd11});

      // Reserved op passes S; S_Out ignores s_sel
      load(3'd6, 16'h0F0F);
      drive(3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 4'b1010, 16'hCAFE);
      #1;
      chk("rsv_1010", {13'h0, bus.N, bus.Z, bus.C, bus.Alu_Out}, {13'h0, 3'b000, 16'd11});
      drive(3'd0, 3'd0, 3'd6, 1'b1, 1'b0, ALU_PASS, 16'hCAFE);
      #1;
      chk("sout_ssel", {bus.S_Out, bus.Alu_Out}, {16'h0F0F, 16'hCAFE});

      // Reset held across an edge with rw_en set: no write
      load(3'd5, 16'h1111);
      drive(3'd5, 3'd0, 3'd0, 1'b1, 1'b1, ALU_PASS, 16'hBEEF);
      reset = 1'b0;
      @(posedge clk);
      #1;
      bus.rw_en = 1'b0;
      reset = 1'b1;
      rd("rst_wins_r5", 3'd5, 16'h0000);
      rd("rst_clr_r6", 3'd6, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/cpu_exec_unit.md
Name: cpu_exec_unit

Overview:
Datapath execution unit directly downstream of the control unit. It consumes the control word fields W_Adr/R_Adr/S_Adr, s_sel, rw_en and alu_op. It holds the 8x16 register file and the 16-bit ALU. It returns the N/Z/C status to the control unit, which registers them as present-state flags, and supplies the address and write data to memory.

Parameters:
DATA_W, 16, datapath and register width
ADDR_W, 3, register address width; register count = 2**ADDR_W = 8

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset (reset==0 clears state)
W_Adr  in  ADDR_W  register file write address
R_Adr  in  ADDR_W  register file R read address
S_Adr  in  ADDR_W  register file S read address
s_sel  in  1  ALU S-operand select: 0 = register S port, 1 = DS (memory data)
rw_en  in  1  register file write enable
alu_op  in  4  ALU operation code
DS  in  DATA_W  data from memory
Reg_Out  out  DATA_W  register R port value (memory address source when adr_sel=1)
Alu_Out  out  DATA_W  ALU result (register write data)
S_Out  out  DATA_W  register S port value (memory write data for STO)
N  out  1  result bit DATA_W-1
Z  out  1  result == 0
C  out  1  carry/borrow/shifted-out bit, per the op rules below

Behaviour:
- Reset, asynchronous on reset==0:
  - all 8 registers clear to 16'h0000 immediately, independent of clk.
  - With all-zero addresses: Reg_Out=S_Out=0, Alu_Out=0, N=0, Z=1, C=0 (pass of 0).
- Reset deassertion is synchronised externally. The first write can occur on the first rising clk edge after reset goes to 1.
- Register write:
  - On posedge clk with reset==1 and rw_en==1: R[W_Adr] <= Alu_Out.
  - rw_en==0: no register changes.
  - R0 is an ordinary writable register.
- Reads are combinational (zero latency) on both the R and S ports.
- Read-during-write to the same address returns the OLD value until the edge. There is no bypass.
- S operand: S_op = s_sel ? DS : R[S_Adr]. R operand: R_op = R[R_Adr]. S_Out is always R[S_Adr], independent of s_sel.
- ALU operations. All arithmetic is 17-bit internally; Alu_Out is the low 16 bits:
  - 0000 pass: S_op, C=0
  - 0010 inc: S_op+1, C=carry out
  - 0011 dec: S_op-1, C=borrow (S_op==0)
  - 0100 add: R_op+S_op, C=carry out
  - 0101 sub: R_op-S_op, C=borrow (R_op<S_op unsigned)
  - 0110 shr: logical right shift of S_op by 1, zero fill, C=S_op[0]
  - 0111 shl: S_op<<1, C=S_op[15]
  - 0001 and 1xxx are reserved: pass S_op, C=0
- Flags:
  - N=Alu_Out[15] and Z=(Alu_Out==0) for every op.
  - The flags are purely combinational; the control unit decides when to capture them.
- Same-cycle events:
  - rw_en with W_Adr==R_Adr==S_Adr: result uses old values; the register is updated at the edge (e.g. INC R3,R3 increments exactly once per cycle).
  - reset asserted while rw_en==1: reset wins and no write occurs.
  - Reset asserted mid-operation clears all registers regardless of the clock phase.
- No X propagation: every alu_op value maps to a defined result.

Decomposition:
- Shared package (cpu_pkg): DATA_W/ADDR_W defaults and ALU opcode constants (ALU_PASS=0000, ALU_INC=0010, ALU_DEC=0011, ALU_ADD=0100, ALU_SUB=0101, ALU_SHR=0110, ALU_SHL=0111). The control unit uses the same constants.
- One sub-module, cpu_regfile: 8xDATA_W registers with async active-low clear, one write port, two combinational read ports.
- The ALU and s_sel mux stay in cpu_exec_unit as combinational logic.

Test Plan:
- Reset: preload R0..R7=16'hA5A5, pulse reset low mid-cycle -> all reads return 0 immediately; Z=1, N=0, C=0.
- LDI/LD path: s_sel=1, DS=16'h8001, alu_op=0000, W_Adr=2, rw_en=1 -> after edge R2=16'h8001. Before the edge: N=1, Z=0, C=0.
- ADD carry: R1=16'hFFFF, R2=16'h0001, alu_op=0100, R_Adr=1, S_Adr=2, W_Adr=3 -> Alu_Out=0, Z=1, C=1, N=0; R3=0 after edge.
- SUB/CMP borrow: R1=5, R2=7, alu_op=0101, rw_en=0 -> Alu_Out=16'hFFFE, N=1, C=1, Z=0; no register changes.
- Shifts: S=16'h8001: shl -> 16'h0002, C=1; shr -> 16'h4000, C=1. S=16'h0001 dec -> 0, Z=1, C=0. S=0 dec -> 16'hFFFF, C=1.
- Read-during-write: INC R4,R4 with R4=9 -> Reg_Out/S_Out show 9 during the cycle, 10 after the edge. Reserved op 4'b1010 -> pass S, C=0.
